// File: rtl/btn_conditioner.sv
// Push-button front end: 2-flop sync, debounce, press/auto-repeat pulse generation, pair conflict filter.
// Optional macro BTN_AUTOREPEAT_EN compiles in the hold/repeat timers (PRESSED->REPEAT path).
module btn_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned HOLD_CYCLES     = 25000000,
  parameter int unsigned REPEAT_CYCLES   = 10000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_n,
  output logic       inc_min_pulse,
  output logic       dec_min_pulse,
  output logic       inc_hour_pulse,
  output logic       dec_hour_pulse,
  output logic [3:0] btn_held
);

  localparam int unsigned NB = 4;
  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
`ifdef BTN_AUTOREPEAT_EN
  localparam int unsigned TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned TW   = $clog2(TMAX + 1);
`endif

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESSED,
    ST_REPEAT
  } state_e;

  logic [NB-1:0] sync1_q, sync1_d;
  logic [NB-1:0] sync2_q, sync2_d;
  logic [NB-1:0] held_q, held_d;
  logic [DW-1:0] db_cnt_q [NB];
  logic [DW-1:0] db_cnt_d [NB];
  state_e        state_q  [NB];
  state_e        state_d  [NB];
  logic [NB-1:0] raw_pulse;
  logic [NB-1:0] pulse_q, pulse_d;
`ifdef BTN_AUTOREPEAT_EN
  logic [TW-1:0] tmr_q [NB];
  logic [TW-1:0] tmr_d [NB];
`endif

  // Synchroniser and debounce: accept a level after DEBOUNCE_CYCLES consecutive differing samples
  always_comb begin
    sync1_d = ~btn_n;
    sync2_d = sync1_q;
    held_d  = held_q;
    for (int i = 0; i < NB; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != held_q[i]) begin
        if (db_cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          held_d[i] = ~held_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DW'(1);
        end
      end
    end
  end

  // Per-channel press / auto-repeat FSM; release always wins over a due pulse
  always_comb begin
    raw_pulse = '0;
    for (int i = 0; i < NB; i++) begin
      state_d[i] = state_q[i];
`ifdef BTN_AUTOREPEAT_EN
      tmr_d[i] = tmr_q[i];
`endif
      case (state_q[i])
        ST_IDLE: begin
          if (held_q[i]) begin
            state_d[i]   = ST_PRESSED;
            raw_pulse[i] = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
            tmr_d[i] = '0;
`endif
          end
        end
        ST_PRESSED: begin
          if (!held_q[i]) begin
            state_d[i] = ST_IDLE;
`ifdef BTN_AUTOREPEAT_EN
            tmr_d[i] = '0;
          end else if (tmr_q[i] == TW'(HOLD_CYCLES - 1)) begin
            state_d[i]   = ST_REPEAT;
            raw_pulse[i] = 1'b1;
            tmr_d[i]     = '0;
          end else begin
            tmr_d[i] = tmr_q[i] + TW'(1);
`endif
          end
        end
        ST_REPEAT: begin
`ifdef BTN_AUTOREPEAT_EN
          if (!held_q[i]) begin
            state_d[i] = ST_IDLE;
            tmr_d[i]   = '0;
          end else if (tmr_q[i] == TW'(REPEAT_CYCLES - 1)) begin
            raw_pulse[i] = 1'b1;
            tmr_d[i]     = '0;
          end else begin
            tmr_d[i] = tmr_q[i] + TW'(1);
          end
`else
          state_d[i] = ST_IDLE;
`endif
        end
        default: state_d[i] = ST_IDLE;
      endcase
    end
  end

  // Suppress a pair's pulses while both of its buttons are held
  always_comb begin
    logic conflict_min;
    logic conflict_hour;
    conflict_min  = held_q[0] & held_q[1];
    conflict_hour = held_q[2] & held_q[3];
    pulse_d = raw_pulse & ~{conflict_hour, conflict_hour, conflict_min, conflict_min};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      held_q  <= '0;
      pulse_q <= '0;
      for (int i = 0; i < NB; i++) begin
        db_cnt_q[i] <= '0;
        state_q[i]  <= ST_IDLE;
`ifdef BTN_AUTOREPEAT_EN
        tmr_q[i] <= '0;
`endif
      end
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      held_q  <= held_d;
      pulse_q <= pulse_d;
      for (int i = 0; i < NB; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
        state_q[i]  <= state_d[i];
`ifdef BTN_AUTOREPEAT_EN
        tmr_q[i] <= tmr_d[i];
`endif
      end
    end
  end

  assign inc_min_pulse  = pulse_q[0];
  assign dec_min_pulse  = pulse_q[1];
  assign inc_hour_pulse = pulse_q[2];
  assign dec_hour_pulse = pulse_q[3];
  assign btn_held       = held_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner: expected pulse cycles are queued at stimulus time and
// compared every cycle against the DUT pulse outputs.
module tb_btn_conditioner;

  localparam int unsigned D = 4;
  localparam int unsigned H = 20;
  localparam int unsigned R = 8;
`ifdef BTN_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] btn_n = 4'hF;
  logic       inc_min_pulse, dec_min_pulse, inc_hour_pulse, dec_hour_pulse;
  logic [3:0] btn_held;

  btn_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES    (H),
    .REPEAT_CYCLES  (R)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .btn_n         (btn_n),
    .inc_min_pulse (inc_min_pulse),
    .dec_min_pulse (dec_min_pulse),
    .inc_hour_pulse(inc_hour_pulse),
    .dec_hour_pulse(dec_hour_pulse),
    .btn_held      (btn_held)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] mask;
  } exp_t;

  exp_t q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   pcnt[4]     = '{0, 0, 0, 0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Merge expectations that land on the same cycle; pushes arrive in cycle order
  task automatic push_exp(input int c, input logic [3:0] m);
    exp_t e;
    if (q.size() > 0 && q[q.size()-1].cyc == c) begin
      q[q.size()-1].mask = q[q.size()-1].mask | m;
    end else begin
      e.cyc  = c;
      e.mask = m;
      q.push_back(e);
    end
  endtask

  // Press driven right after edge t0, release sampled at edge r1: press pulse plus any repeats
  task automatic exp_press(input logic [3:0] m, input int t0, input int r1, output int n);
    int c;
    c = t0 + int'(D) + 3;
    push_exp(c, m);
    n = 1;
    if (AR) begin
      c = c + int'(H);
      while (c <= r1 + int'(D) + 1) begin
        push_exp(c, m);
        n++;
        c = c + int'(R);
      end
    end
  endtask

  task automatic check_pulses();
    logic [3:0] obs;
    logic [3:0] exp;
    exp = 4'b0000;
    if (q.size() > 0 && q[0].cyc == cyc) begin
      exp = q[0].mask;
      void'(q.pop_front());
    end
    obs = {dec_hour_pulse, inc_hour_pulse, dec_min_pulse, inc_min_pulse};
    for (int i = 0; i < 4; i++) pcnt[i] += int'(obs[i]);
    chk("pulses", 32'(obs), 32'(exp));
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      check_pulses();
      @(posedge clk);
      #1;
    end
  endtask

  int t0, m, n, n3, base0, base1, base2, base3;

  initial begin
    // Reset state
    #12;
    chk("rst_held", 32'(btn_held), 32'(0));
    chk("rst_pulses", 32'({dec_hour_pulse, inc_hour_pulse, dec_min_pulse, inc_min_pulse}), 32'(0));
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick(3);

    // 1: clean press on inc_min
    base0 = pcnt[0];
    t0 = cyc;
    btn_n[0] = 1'b0;
    exp_press(4'b0001, t0, t0 + 11, n);
    tick(5);
    chk("t1_held_edge5", 32'(btn_held[0]), 32'(0));
    tick(1);
    chk("t1_held_edge6", 32'(btn_held[0]), 32'(1));
    tick(4);
    btn_n[0] = 1'b1;
    tick(5);
    chk("t1_rel_edge5", 32'(btn_held[0]), 32'(1));
    tick(1);
    chk("t1_rel_edge6", 32'(btn_held[0]), 32'(0));
    tick(10);
    chk("t1_inc_min_count", 32'(pcnt[0] - base0), 32'(1));

    // 2: bounce on inc_hour never gets accepted
    base2 = pcnt[2];
    for (int k = 0; k < 10; k++) begin
      btn_n[2] = k[0];
      for (int j = 0; j < 3; j++) begin
        tick(1);
        chk("t2_held_bounce", 32'(btn_held[2]), 32'(0));
      end
    end
    btn_n[2] = 1'b1;
    tick(10);
    chk("t2_held_settled", 32'(btn_held[2]), 32'(0));
    chk("t2_inc_hour_count", 32'(pcnt[2] - base2), 32'(0));

    // 3: dec_min held long enough for three repeats
    base1 = pcnt[1];
    t0 = cyc;
    btn_n[1] = 1'b0;
    exp_press(4'b0010, t0, t0 + 41, n);
    tick(40);
    btn_n[1] = 1'b1;
    tick(30);
    chk("t3_dec_min_count", 32'(pcnt[1] - base1), AR ? 32'(4) : 32'(1));

    // 4: minute pair conflict, hour channel unaffected
    base0 = pcnt[0];
    base1 = pcnt[1];
    base3 = pcnt[3];
    t0 = cyc;
    btn_n[0] = 1'b0;
    btn_n[3] = 1'b0;
    push_exp(t0 + int'(D) + 3, 4'b0001);
    exp_press(4'b1000, t0, t0 + 61, n3);
    tick(10);
    btn_n[1] = 1'b0;
    tick(50);
    btn_n = 4'hF;
    tick(30);
    chk("t4_inc_min_count", 32'(pcnt[0] - base0), 32'(1));
    chk("t4_dec_min_count", 32'(pcnt[1] - base1), 32'(0));
    chk("t4_dec_hour_count", 32'(pcnt[3] - base3), 32'(n3));

    // 5: reset mid-hold, then the still-held button is a fresh press
    t0 = cyc;
    btn_n[3] = 1'b0;
    push_exp(t0 + int'(D) + 3, 4'b1000);
    tick(15);
    chk("t5_held_before_rst", 32'(btn_held[3]), 32'(1));
    #1;
    rst = 1'b0;
    #1;
    chk("t5_held_in_rst", 32'(btn_held), 32'(0));
    chk("t5_pulses_in_rst", 32'({dec_hour_pulse, inc_hour_pulse, dec_min_pulse, inc_min_pulse}), 32'(0));
    tick(2);
    rst = 1'b1;
    m = cyc;
    exp_press(4'b1000, m, m + 13, n);
    tick(5);
    chk("t5_held_edge5", 32'(btn_held[3]), 32'(0));
    tick(1);
    chk("t5_held_edge6", 32'(btn_held[3]), 32'(1));
    tick(6);
    btn_n[3] = 1'b1;
    tick(20);

    // 6: long hold on inc_hour (one pulse only without auto-repeat)
    base2 = pcnt[2];
    t0 = cyc;
    btn_n[2] = 1'b0;
    exp_press(4'b0100, t0, t0 + 101, n);
    tick(100);
    btn_n[2] = 1'b1;
    tick(30);
    chk("t6_inc_hour_count", 32'(pcnt[2] - base2), AR ? 32'(11) : 32'(1));

    chk("queue_drained", 32'(q.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
